// File: rtl/my_pkg.sv
// Shared constants, fault encoding and helpers for the instruction fetch memory.
package my_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 32;
    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned MEM_DEPTH_DEF   = 4096;
    localparam int unsigned FETCH_WIDTH_DEF = 2;
    localparam logic [31:0] NOP_INST_DEF    = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    // Misalignment outranks an out-of-range base address.
    function automatic fault_e fetch_fault(input logic aligned, input logic base_in_range);
        fault_e f;
        f = FAULT_NONE;
        if (!aligned) begin
            f = FAULT_MISALIGN;
        end else if (!base_in_range) begin
            f = FAULT_RANGE;
        end
        return f;
    endfunction

endpackage

// File: rtl/inst_fetch_mem_if.sv
// Fetch request/response handshake plus program-download write port.
interface inst_fetch_mem_if
    import my_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned FETCH_WIDTH = FETCH_WIDTH_DEF
);

    logic                        req_valid;
    logic                        req_ready;
    logic [ADDR_WIDTH-1:0]       req_addr;

    logic                        resp_valid;
    logic                        resp_ready;
    logic [ADDR_WIDTH-1:0]       resp_addr;
    logic [32*FETCH_WIDTH-1:0]   resp_inst;
    logic [FETCH_WIDTH-1:0]      resp_mask;
    logic [1:0]                  resp_fault;

    logic                        wr_en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [31:0]                 wr_data;
    logic [3:0]                  wr_be;

    modport master (
        output req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data, wr_be,
        input  req_ready, resp_valid, resp_addr, resp_inst, resp_mask, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, wr_en, wr_addr, wr_data, wr_be,
        output req_ready, resp_valid, resp_addr, resp_inst, resp_mask, resp_fault
    );

endinterface

// File: rtl/inst_byte_ram.sv
// Byte-array program store: byte-enabled word write, FETCH_WIDTH combinational word reads.
module inst_byte_ram
    import my_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int unsigned FETCH_WIDTH = FETCH_WIDTH_DEF
) (
    input  logic                                        clk_i,
    input  logic                                        wr_en_i,
    input  logic [ADDR_WIDTH-1:0]                       wr_addr_i,
    input  logic [DATA_WIDTH-1:0]                       wr_data_i,
    input  logic [DATA_WIDTH/8-1:0]                     wr_be_i,
    input  logic [FETCH_WIDTH-1:0][ADDR_WIDTH+2:0]      rd_addr_i,
    output logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0]      rd_data_o,
    output logic [FETCH_WIDTH-1:0]                      rd_in_range_o
);

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);

    typedef logic [IdxW-1:0]       idx_t;
    typedef logic [ADDR_WIDTH+2:0] waddr_t;

    localparam waddr_t DepthW = waddr_t'(MEM_DEPTH);

    logic [7:0] mem_q [MEM_DEPTH];
    logic       wr_hit;
    idx_t       wr_base;

    always_comb begin
        wr_hit  = wr_en_i && (waddr_t'(wr_addr_i) < DepthW);
        wr_base = idx_t'(wr_addr_i) & ~idx_t'(3);
    end

    always_ff @(posedge clk_i) begin
        if (wr_hit) begin
            for (int k = 0; k < DATA_WIDTH / 8; k++) begin
                if (wr_be_i[k]) begin
                    mem_q[wr_base + idx_t'(k)] <= wr_data_i[8*k +: 8];
                end
            end
        end
    end

    // Out-of-range ports still read (wrapped) bytes; the caller masks them via rd_in_range_o.
    always_comb begin
        rd_data_o     = '0;
        rd_in_range_o = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            rd_in_range_o[i] = (rd_addr_i[i] + waddr_t'(3)) < DepthW;
            for (int k = 0; k < DATA_WIDTH / 8; k++) begin
                rd_data_o[i][8*k +: 8] = mem_q[idx_t'(rd_addr_i[i]) + idx_t'(k)];
            end
        end
    end

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: one-cycle fetch groups with per-slot mask, fault code and flush.
module inst_fetch_mem
    import my_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int unsigned FETCH_WIDTH = FETCH_WIDTH_DEF,
    parameter logic [31:0] NOP_INST    = NOP_INST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    inst_fetch_mem_if.slave  bus
);

    typedef logic [ADDR_WIDTH+2:0] waddr_t;

    logic [FETCH_WIDTH-1:0][ADDR_WIDTH+2:0] slot_addr;
    logic [FETCH_WIDTH-1:0][31:0]           slot_data;
    logic [FETCH_WIDTH-1:0]                 slot_in_range;

    logic                         aligned;
    fault_e                       fault_n;
    logic [FETCH_WIDTH-1:0]       mask_n;
    logic [FETCH_WIDTH-1:0][31:0] inst_n;
    logic                         req_ready;
    logic                         accept;

    logic                         resp_valid_d, resp_valid_q;
    logic [ADDR_WIDTH-1:0]        resp_addr_d, resp_addr_q;
    logic [FETCH_WIDTH-1:0][31:0] resp_inst_d, resp_inst_q;
    logic [FETCH_WIDTH-1:0]       resp_mask_d, resp_mask_q;
    fault_e                       resp_fault_d, resp_fault_q;

    inst_byte_ram #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MEM_DEPTH   (MEM_DEPTH),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_ram (
        .clk_i         (clk),
        .wr_en_i       (bus.wr_en),
        .wr_addr_i     (bus.wr_addr),
        .wr_data_i     (bus.wr_data),
        .wr_be_i       (bus.wr_be),
        .rd_addr_i     (slot_addr),
        .rd_data_o     (slot_data),
        .rd_in_range_o (slot_in_range)
    );

    // Slot addresses are widened so a base near the top of the address space cannot wrap.
    always_comb begin
        slot_addr = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_addr[i] = waddr_t'(bus.req_addr) + waddr_t'(4 * i);
        end
    end

    always_comb begin
        aligned = (bus.req_addr[1:0] == 2'b00);
        fault_n = fetch_fault(aligned, slot_in_range[0]);
        mask_n  = '0;
        inst_n  = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            mask_n[i] = (fault_n == FAULT_NONE) && slot_in_range[i];
            inst_n[i] = mask_n[i] ? slot_data[i] : NOP_INST;
        end
    end

    always_comb begin
        req_ready    = !flush && (!resp_valid_q || bus.resp_ready);
        accept       = bus.req_valid && req_ready;
        resp_valid_d = resp_valid_q;
        resp_addr_d  = resp_addr_q;
        resp_inst_d  = resp_inst_q;
        resp_mask_d  = resp_mask_q;
        resp_fault_d = resp_fault_q;
        if (flush) begin
            resp_valid_d = 1'b0;
        end else if (accept) begin
            resp_valid_d = 1'b1;
            resp_addr_d  = bus.req_addr;
            resp_inst_d  = inst_n;
            resp_mask_d  = mask_n;
            resp_fault_d = fault_n;
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_inst_q  <= '0;
            resp_mask_q  <= '0;
            resp_fault_q <= FAULT_NONE;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_inst_q  <= resp_inst_d;
            resp_mask_q  <= resp_mask_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_addr  = resp_addr_q;
    assign bus.resp_inst  = resp_inst_q;
    assign bus.resp_mask  = resp_mask_q;
    assign bus.resp_fault = resp_fault_q;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Randomized bench for inst_fetch_mem against a behavioural byte-array model, plus directed pins.
module tb_inst_fetch_mem;

    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int FW    = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    logic flush;

    inst_fetch_mem_if #(.ADDR_WIDTH(AW), .FETCH_WIDTH(FW)) bus ();

    inst_fetch_mem #(
        .ADDR_WIDTH  (AW),
        .MEM_DEPTH   (DEPTH),
        .FETCH_WIDTH (FW),
        .NOP_INST    (NOP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model state.
    logic [7:0]  mm [DEPTH];
    logic        m_valid = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [63:0] m_inst  = '0;
    logic [1:0]  m_mask  = '0;
    logic [1:0]  m_fault = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // What a fetch of address a must return, from memory contents as they stand now.
    function automatic void form(input logic [31:0] a, output logic [63:0] inst,
                                 output logic [1:0] mask, output logic [1:0] fault);
        longint unsigned base;
        longint unsigned s;
        base = {32'd0, a};
        if (a[1:0] != 2'b00)    fault = 2'b01;
        else if (base >= DEPTH) fault = 2'b10;
        else                    fault = 2'b00;
        inst = '0;
        mask = '0;
        for (int i = 0; i < FW; i++) begin
            s = base + 64'(4 * i);
            if (fault == 2'b00 && s + 3 < DEPTH) begin
                inst[32*i +: 32] = {mm[int'(s) + 3], mm[int'(s) + 2], mm[int'(s) + 1], mm[int'(s)]};
                mask[i] = 1'b1;
            end else begin
                inst[32*i +: 32] = NOP;
            end
        end
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic        acc;
        logic [63:0] fi;
        logic [1:0]  fm;
        logic [1:0]  ff;
        int          wb;
        acc = bus.req_valid && !flush && (!m_valid || bus.resp_ready);
        form(bus.req_addr, fi, fm, ff);
        if (rst) begin
            m_valid = 1'b0; m_addr = '0; m_inst = '0; m_mask = '0; m_fault = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1; m_addr = bus.req_addr; m_inst = fi; m_mask = fm; m_fault = ff;
        end else if (m_valid && bus.resp_ready) begin
            m_valid = 1'b0;
        end
        if (bus.wr_en && {32'd0, bus.wr_addr} < DEPTH) begin
            wb = int'(bus.wr_addr) & ~3;
            for (int k = 0; k < 4; k++) begin
                if (bus.wr_be[k]) mm[wb + k] = bus.wr_data[8*k +: 8];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic drive(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                         input logic rs, input logic we, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [3:0] be);
        bus.req_valid  = rv;
        bus.req_addr   = ra;
        bus.resp_ready = rr;
        flush          = fl;
        rst            = rs;
        bus.wr_en      = we;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.wr_be      = be;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(bus.req_ready), 64'(!flush && (!m_valid || bus.resp_ready)));
            chk("resp_valid", 64'(bus.resp_valid), 64'(m_valid));
            if (m_valid) begin
                chk("resp_addr", 64'(bus.resp_addr), 64'(m_addr));
                chk("resp_inst", bus.resp_inst, m_inst);
                chk("resp_mask", 64'(bus.resp_mask), 64'(m_mask));
                chk("resp_fault", 64'(bus.resp_fault), 64'(m_fault));
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          sel;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 4'h0);
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_inst", bus.resp_inst, 64'd0);
        chk("rst_mask", 64'(bus.resp_mask), 64'd0);
        chk("rst_fault", 64'(bus.resp_fault), 64'd0);
        chk("rst_addr", 64'(bus.resp_addr), 64'd0);

        // Preload the whole array so every later read is defined.
        for (int w = 0; w < DEPTH / 4; w++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 32'(4 * w), $urandom, 4'hF);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h1111_1111, 4'hF); tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h2222_2222, 4'hF); tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3C, 32'h3333_3333, 4'hF); tick();

        // Aligned full group.
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        tick();
        idle();
        chk("t1_valid", 64'(bus.resp_valid), 64'd1);
        chk("t1_inst", bus.resp_inst, 64'h2222_2222_1111_1111);
        chk("t1_mask", 64'(bus.resp_mask), 64'h3);
        chk("t1_fault", 64'(bus.resp_fault), 64'h0);
        chk("t1_model_pin", m_inst, 64'h2222_2222_1111_1111);
        tick();

        // Misaligned.
        drive(1'b1, 32'h6, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        tick();
        idle();
        chk("mis_inst", bus.resp_inst, 64'h0000_0013_0000_0013);
        chk("mis_mask", 64'(bus.resp_mask), 64'h0);
        chk("mis_fault", 64'(bus.resp_fault), 64'h1);

        // Partial group at the last word.
        drive(1'b1, 32'h3C, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        tick();
        chk("part_inst", bus.resp_inst, 64'h0000_0013_3333_3333);
        chk("part_mask", 64'(bus.resp_mask), 64'h1);
        chk("part_fault", 64'(bus.resp_fault), 64'h0);
        chk("part_model_pin", 64'(m_mask), 64'h1);

        // Out of range, back to back with the previous request.
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        tick();
        chk("oor_inst", bus.resp_inst, 64'h0000_0013_0000_0013);
        chk("oor_mask", 64'(bus.resp_mask), 64'h0);
        chk("oor_fault", 64'(bus.resp_fault), 64'h2);

        // Back-pressure: hold addr 0 for three cycles, then accept addr 4 with no bubble.
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        tick();
        drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        #1;
        chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_valid", 64'(bus.resp_valid), 64'd1);
            chk("bp_hold_addr", 64'(bus.resp_addr), 64'h0);
            chk("bp_hold_inst", bus.resp_inst, 64'h2222_2222_1111_1111);
        end
        drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        #1;
        chk("bp_release_ready", 64'(bus.req_ready), 64'd1);
        tick();
        chk("bp_next_valid", 64'(bus.resp_valid), 64'd1);
        chk("bp_next_addr", 64'(bus.resp_addr), 64'h4);
        chk("bp_next_slot0", 64'(bus.resp_inst[31:0]), 64'h2222_2222);

        // Flush with a held response and a pending request.
        drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 4'h0);
        #1;
        chk("fl_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        chk("fl_valid", 64'(bus.resp_valid), 64'd0);
        idle();
        tick();
        chk("fl_dropped", 64'(bus.resp_valid), 64'd0);

        // Reset mid-stream.
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        tick();
        chk("pre_rst_valid", 64'(bus.resp_valid), 64'd1);
        drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 4'h0);
        tick();
        chk("mid_rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("mid_rst_inst", bus.resp_inst, 64'd0);
        chk("mid_rst_mask", 64'(bus.resp_mask), 64'd0);
        chk("mid_rst_fault", 64'(bus.resp_fault), 64'd0);

        // Byte write with a fetch of the same word on the same edge: read-first.
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_AB00, 4'b0010);
        tick();
        chk("rdw_old", 64'(bus.resp_inst[31:0]), 64'h1111_1111);
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        tick();
        chk("rdw_new", 64'(bus.resp_inst[31:0]), 64'h1111_AB11);
        chk("rdw_mask", 64'(bus.resp_mask), 64'h3);
        idle();
        tick();

        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 4)      a = 32'($urandom_range(0, 15) * 4);
            else if (sel == 5) a = ($urandom_range(0, 1) != 0) ? 32'h38 : 32'h3C;
            else if (sel == 6) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (sel == 7) a = 32'($urandom_range(16, 100) * 4);
            else if (sel == 8) a = 32'hFFFF_FFFC;
            else               a = $urandom;
            drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63)),
                  $urandom, 4'($urandom_range(0, 15)));
            tick();
        end

        idle();
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
